icb_stream_mas: RTL and testbench
=================================

ICB_STREAM_MAS -- requirements
Module: icb_stream_mas

Interface
REQ-001 Parameter AW, 32, ICB address width.
REQ-002 Parameter DW, 32, ICB data width; wmask width DW/8.
REQ-003 Parameter RD_BASE, 32'h2000_0000, base of read bank 0.
REQ-004 Parameter BANK_STRIDE, 32'h1000_0000, address distance between read banks.
REQ-005 Parameter NBANK, 2, number of read banks (1..4), rotated round-robin.
REQ-006 Parameter WR_BASE, 32'h2000_0000, write region base.
REQ-007 Parameter RD_LEN, 16'hC658, read beats per run; WR_LEN, 16'hC400, write beats per run; both >=1.
REQ-008 Parameter ADDR_STEP, 1, address increment per beat.
REQ-009 Parameter MAX_OUTST, 4, maximum outstanding ICB commands (power of 2, >=1).
REQ-010 Ports: clk in 1 clock; rst in 1 synchronous active-high reset.
REQ-011 Ports: start in 1 begin run pulse; busy out 1 run active; bank out 2 current read bank.
REQ-012 Ports: mas_icb_cmd_valid out 1, mas_icb_cmd_ready in 1, mas_icb_cmd_addr out AW, mas_icb_cmd_read out 1, mas_icb_cmd_wdata out DW, mas_icb_cmd_wmask out DW/8.
REQ-013 Ports: mas_icb_rsp_valid in 1, mas_icb_rsp_ready out 1, mas_icb_rsp_rdata in DW, mas_icb_rsp_err in 1.
REQ-014 Ports: valid_to_acce out 1, data_to_acce out DW (read stream); valid_from_acce in 1, data_from_acce in DW, ready_to_acce out 1 (write stream).
REQ-015 Ports: conv_irq out 1 run-done interrupt; irq_clr in 1; err out 1 sticky bus error.

Function
REQ-016 FSM states IDLE, RD, RD_DRAIN, WR, WR_DRAIN; IDLE->RD on start; start ignored outside IDLE.
REQ-017 RD: cmd_valid=1, cmd_read=1 while rd_cnt<RD_LEN and outst<MAX_OUTST; addr=RD_BASE+bank*BANK_STRIDE+rd_cnt*ADDR_STEP.
REQ-018 rd_cnt increments per cmd handshake; on handshake of beat RD_LEN-1 go RD_DRAIN.
REQ-019 RD_DRAIN: no cmd; ->WR when outst==0.
REQ-020 WR: cmd_valid=valid_from_acce and outst<MAX_OUTST, cmd_read=0, wdata=data_from_acce, wmask all ones, addr=WR_BASE+wr_cnt*ADDR_STEP; ready_to_acce=cmd_ready and outst<MAX_OUTST.
REQ-021 On handshake of write beat WR_LEN-1 go WR_DRAIN; ->IDLE when outst==0, same edge: conv_irq<=1, bank<=(bank+1) mod NBANK.
REQ-022 outst: +1 on cmd handshake, -1 on rsp handshake, unchanged when both same cycle; never exceeds MAX_OUTST.
REQ-023 mas_icb_rsp_ready=1 always; valid_to_acce=rsp_valid and state in {RD,RD_DRAIN}; data_to_acce=rsp_rdata, combinational, zero latency.
REQ-024 err set on rsp_valid&&rsp_err, cleared only by reset or start; run continues on error.
REQ-025 conv_irq sticky until irq_clr; irq_clr and set same cycle: set wins.
REQ-026 busy=1 in every state except IDLE.
REQ-027 Counters are log2(max(RD_LEN,WR_LEN))+1 bits; address arithmetic modulo 2^AW.

Reset
REQ-028 rst sampled on clk only; forces IDLE, rd_cnt=wr_cnt=outst=0, bank=0, conv_irq=0, err=0, all cmd/valid/ready outputs 0 except rsp_ready=1.
REQ-029 rst mid-run abandons outstanding transactions; responses arriving after reset are accepted and dropped.

Structure
REQ-030 Shared package icb_stream_pkg holds FSM state enum and default base/length constants.
REQ-031 One sub-module icb_outst_cnt (up/down counter with full flag) is natural; all else in top.

Verification
REQ-032 RD_LEN=4, WR_LEN=2, ready=1, 1-cycle rsp: read addrs 2000_0000..2000_0003, writes 2000_0000/0001, conv_irq=1, bank=1.
REQ-033 rsp held off 10 cycles, MAX_OUTST=4: exactly 4 cmd handshakes then cmd_valid=0 until first rsp.
REQ-034 Two runs NBANK=2: second run reads from 3000_0000; third run back at 2000_0000.
REQ-035 valid_from_acce toggling in WR: no write beat issued when low, wr_cnt unchanged.
REQ-036 rsp_err on read beat 2: err=1, run completes, conv_irq=1; irq_clr drops conv_irq next cycle.
REQ-037 rst asserted in RD with 3 outstanding: next cycle IDLE, outputs at reset values, late rsp produce no valid_to_acce.

Source files
------------

// File: rtl/icb_stream_pkg.sv
// Shared FSM state encoding and default configuration for the ICB stream master.
package icb_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_RD_DRAIN,
        ST_WR,
        ST_WR_DRAIN
    } state_e;

    localparam int unsigned DEF_AW          = 32;
    localparam int unsigned DEF_DW          = 32;
    localparam logic [31:0] DEF_RD_BASE     = 32'h2000_0000;
    localparam logic [31:0] DEF_BANK_STRIDE = 32'h1000_0000;
    localparam logic [31:0] DEF_WR_BASE     = 32'h2000_0000;
    localparam int unsigned DEF_NBANK       = 2;
    localparam int unsigned DEF_RD_LEN      = 32'h0000_C658;
    localparam int unsigned DEF_WR_LEN      = 32'h0000_C400;
    localparam int unsigned DEF_ADDR_STEP   = 1;
    localparam int unsigned DEF_MAX_OUTST   = 4;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/icb_outst_cnt.sv
// Outstanding ICB command counter; a response with nothing outstanding is ignored.
module icb_outst_cnt #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic full,
    output logic zero
);

    localparam int unsigned CW = $clog2(MAX) + 1;

    logic [CW-1:0] cnt;
    logic          dec_ok;

    // Stray responses (e.g. left over from an abandoned run) must not underflow.
    assign dec_ok = dec && ((cnt != '0) || inc);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !dec_ok) begin
            cnt <= cnt + CW'(1);
        end else if (dec_ok && !inc) begin
            cnt <= cnt - CW'(1);
        end
    end

    assign full = (cnt == CW'(MAX));
    assign zero = (cnt == '0);

endmodule

// File: rtl/icb_stream_mas.sv
// ICB bus master: streams a read run out to an accelerator, then writes its results back,
// rotating the read bank after each completed run.
module icb_stream_mas
    import icb_stream_pkg::*;
#(
    parameter int unsigned     AW          = DEF_AW,
    parameter int unsigned     DW          = DEF_DW,
    parameter logic [AW-1:0]   RD_BASE     = AW'(DEF_RD_BASE),
    parameter logic [AW-1:0]   BANK_STRIDE = AW'(DEF_BANK_STRIDE),
    parameter int unsigned     NBANK       = DEF_NBANK,
    parameter logic [AW-1:0]   WR_BASE     = AW'(DEF_WR_BASE),
    parameter int unsigned     RD_LEN      = DEF_RD_LEN,
    parameter int unsigned     WR_LEN      = DEF_WR_LEN,
    parameter int unsigned     ADDR_STEP   = DEF_ADDR_STEP,
    parameter int unsigned     MAX_OUTST   = DEF_MAX_OUTST
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic [1:0]        bank,

    output logic              mas_icb_cmd_valid,
    input  logic              mas_icb_cmd_ready,
    output logic [AW-1:0]     mas_icb_cmd_addr,
    output logic              mas_icb_cmd_read,
    output logic [DW-1:0]     mas_icb_cmd_wdata,
    output logic [DW/8-1:0]   mas_icb_cmd_wmask,

    input  logic              mas_icb_rsp_valid,
    output logic              mas_icb_rsp_ready,
    input  logic [DW-1:0]     mas_icb_rsp_rdata,
    input  logic              mas_icb_rsp_err,

    output logic              valid_to_acce,
    output logic [DW-1:0]     data_to_acce,
    input  logic              valid_from_acce,
    input  logic [DW-1:0]     data_from_acce,
    output logic              ready_to_acce,

    output logic              conv_irq,
    input  logic              irq_clr,
    output logic              err
);

    localparam int unsigned   CW        = $clog2(max_u(RD_LEN, WR_LEN)) + 1;
    localparam logic [CW-1:0] RD_LEN_C  = CW'(RD_LEN);
    localparam logic [CW-1:0] RD_LAST   = CW'(RD_LEN - 1);
    localparam logic [CW-1:0] WR_LAST   = CW'(WR_LEN - 1);
    localparam logic [1:0]    BANK_LAST = 2'(NBANK - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] rd_cnt, wr_cnt;
    logic [AW-1:0] rd_addr, wr_addr;
    logic          outst_full, outst_zero;
    logic          rd_issue, wr_issue;
    logic          cmd_hs, rsp_hs, start_acc, run_done;

    icb_outst_cnt #(
        .MAX (MAX_OUTST)
    ) u_outst (
        .clk  (clk),
        .rst  (rst),
        .inc  (cmd_hs),
        .dec  (rsp_hs),
        .full (outst_full),
        .zero (outst_zero)
    );

    // Command issue conditions, kept apart from the FSM so handshakes feed back cleanly.
    assign rd_issue  = (state_q == ST_RD) && (rd_cnt < RD_LEN_C) && !outst_full;
    assign wr_issue  = (state_q == ST_WR) && valid_from_acce && !outst_full;
    assign cmd_hs    = mas_icb_cmd_valid && mas_icb_cmd_ready;
    assign rsp_hs    = mas_icb_rsp_valid && mas_icb_rsp_ready;
    assign start_acc = (state_q == ST_IDLE) && start;

    assign rd_addr = RD_BASE + (AW'(bank) * BANK_STRIDE) + (AW'(rd_cnt) * AW'(ADDR_STEP));
    assign wr_addr = WR_BASE + (AW'(wr_cnt) * AW'(ADDR_STEP));

    assign mas_icb_cmd_valid = rd_issue || wr_issue;
    assign mas_icb_cmd_read  = (state_q == ST_RD);
    assign mas_icb_cmd_addr  = (state_q == ST_RD) ? rd_addr :
                               (state_q == ST_WR) ? wr_addr : '0;
    assign mas_icb_cmd_wdata = (state_q == ST_WR) ? data_from_acce : '0;
    assign mas_icb_cmd_wmask = (state_q == ST_WR) ? '1 : '0;
    assign ready_to_acce     = (state_q == ST_WR) && mas_icb_cmd_ready && !outst_full;

    assign mas_icb_rsp_ready = 1'b1;
    assign valid_to_acce     = mas_icb_rsp_valid && ((state_q == ST_RD) || (state_q == ST_RD_DRAIN));
    assign data_to_acce      = mas_icb_rsp_rdata;
    assign busy              = (state_q != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        run_done = 1'b0;
        unique case (state_q)
            ST_IDLE:     if (start) state_d = ST_RD;
            ST_RD:       if (cmd_hs && (rd_cnt == RD_LAST)) state_d = ST_RD_DRAIN;
            ST_RD_DRAIN: if (outst_zero) state_d = ST_WR;
            ST_WR:       if (cmd_hs && (wr_cnt == WR_LAST)) state_d = ST_WR_DRAIN;
            ST_WR_DRAIN: begin
                if (outst_zero) begin
                    state_d  = ST_IDLE;
                    run_done = 1'b1;
                end
            end
            default:     state_d = ST_IDLE;
        endcase
    end

    // Beat counters restart with every accepted run.
    always_ff @(posedge clk) begin
        if (rst || start_acc) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
        end else if (cmd_hs) begin
            if (state_q == ST_RD) begin
                rd_cnt <= rd_cnt + CW'(1);
            end else begin
                wr_cnt <= wr_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bank <= '0;
        end else if (run_done) begin
            bank <= (bank == BANK_LAST) ? 2'd0 : bank + 2'd1;
        end
    end

    // Interrupt set has priority over a coincident clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            conv_irq <= 1'b0;
        end else if (run_done) begin
            conv_irq <= 1'b1;
        end else if (irq_clr) begin
            conv_irq <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            err <= 1'b0;
        end else if (rsp_hs && mas_icb_rsp_err) begin
            err <= 1'b1;
        end else if (start_acc) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_icb_stream_mas.sv
// Randomized bench for icb_stream_mas: ICB slave + accelerator models feed a run-level reference.
module tb_icb_stream_mas;

    localparam int unsigned AW          = 32;
    localparam int unsigned DW          = 32;
    localparam logic [31:0] RD_BASE     = 32'h2000_0000;
    localparam logic [31:0] BANK_STRIDE = 32'h1000_0000;
    localparam logic [31:0] WR_BASE     = 32'h2000_0000;
    localparam int unsigned NBANK       = 2;
    localparam int unsigned RD_LEN      = 6;
    localparam int unsigned WR_LEN      = 3;
    localparam int unsigned ADDR_STEP   = 1;
    localparam int unsigned MAX_OUTST   = 4;

    typedef struct {
        logic [31:0] addr;
        logic        read;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } cmd_t;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          due;
        logic        is_read;
    } pend_t;

    logic            clk = 1'b0;
    logic            rst, start, busy, irq_clr, conv_irq, err;
    logic [1:0]      bank;
    logic            cmd_valid, cmd_ready, cmd_read;
    logic [AW-1:0]   cmd_addr;
    logic [DW-1:0]   cmd_wdata;
    logic [DW/8-1:0] cmd_wmask;
    logic            rsp_valid, rsp_ready, rsp_err;
    logic [DW-1:0]   rsp_rdata;
    logic            valid_to_acce, valid_from_acce, ready_to_acce;
    logic [DW-1:0]   data_to_acce, data_from_acce;

    cmd_t        cmd_log[$];
    pend_t       pend[$];
    logic [31:0] rd_obs[$];
    logic [31:0] rd_exp[$];
    logic [31:0] acc_log[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int outst_b = 0;
    int read_idx = 0;
    int err_beat = -1;
    int lat_min = 1, lat_max = 1, rdy_rate = 100, acc_rate = 100;
    int hs_before = 0;
    int rsp_seen = 0;
    int last_due = 0;
    int bank_m = 0;

    icb_stream_mas #(
        .AW(AW), .DW(DW), .RD_BASE(RD_BASE), .BANK_STRIDE(BANK_STRIDE), .NBANK(NBANK),
        .WR_BASE(WR_BASE), .RD_LEN(RD_LEN), .WR_LEN(WR_LEN), .ADDR_STEP(ADDR_STEP),
        .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .bank(bank),
        .mas_icb_cmd_valid(cmd_valid), .mas_icb_cmd_ready(cmd_ready),
        .mas_icb_cmd_addr(cmd_addr), .mas_icb_cmd_read(cmd_read),
        .mas_icb_cmd_wdata(cmd_wdata), .mas_icb_cmd_wmask(cmd_wmask),
        .mas_icb_rsp_valid(rsp_valid), .mas_icb_rsp_ready(rsp_ready),
        .mas_icb_rsp_rdata(rsp_rdata), .mas_icb_rsp_err(rsp_err),
        .valid_to_acce(valid_to_acce), .data_to_acce(data_to_acce),
        .valid_from_acce(valid_from_acce), .data_from_acce(data_from_acce),
        .ready_to_acce(ready_to_acce),
        .conv_irq(conv_irq), .irq_clr(irq_clr), .err(err)
    );

    always #5 clk = ~clk;

    // Slave + accelerator model: drive at negedge, observe handshakes 1 time unit later.
    initial begin
        logic  acc_take, hs;
        pend_t p;
        int    lat;
        acc_take = 1'b0;
        cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_rdata = '0; rsp_err = 1'b0;
        valid_from_acce = 1'b0; data_from_acce = '0;
        forever begin
            @(negedge clk);
            cyc++;
            cmd_ready = ($urandom_range(0, 99) < rdy_rate);
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                rsp_valid = 1'b1;
                rsp_rdata = pend[0].data;
                rsp_err   = pend[0].err;
                if (pend[0].is_read) rd_exp.push_back(pend[0].data);
                pend.delete(0);
            end else begin
                rsp_valid = 1'b0;
                rsp_rdata = $urandom;
                rsp_err   = 1'b0;
            end
            if (acc_take || !valid_from_acce) begin
                valid_from_acce = ($urandom_range(0, 99) < acc_rate);
                data_from_acce  = $urandom;
            end
            #1;
            acc_take = ready_to_acce && valid_from_acce;
            hs = cmd_valid && cmd_ready;
            checks++;
            if (rsp_ready !== 1'b1) begin
                errors++;
                $display("FAIL rsp_ready: got %b expected 1 (cycle %0d)", rsp_ready, cyc);
            end
            checks++;
            if (cmd_valid === 1'b1 && outst_b >= MAX_OUTST) begin
                errors++;
                $display("FAIL outst_limit: cmd_valid=1 with %0d outstanding, limit %0d", outst_b, MAX_OUTST);
            end
            checks++;
            if ((hs && !cmd_read) !== acc_take) begin
                errors++;
                $display("FAIL wr_pairing: write cmd handshake %b vs accel handshake %b (cycle %0d)",
                         hs && !cmd_read, acc_take, cyc);
            end
            if (valid_to_acce === 1'b1) rd_obs.push_back(data_to_acce);
            if (rst) begin
                outst_b  = 0;
                acc_take = 1'b0;
            end else begin
                if (rsp_valid) rsp_seen = 1;
                if (hs) begin
                    cmd_log.push_back('{addr: cmd_addr, read: cmd_read, wdata: cmd_wdata, wmask: cmd_wmask});
                    if (rsp_seen == 0) hs_before++;
                    lat = $urandom_range(lat_min, lat_max);
                    p.due = cyc + lat;
                    if (p.due <= last_due) p.due = last_due + 1;
                    last_due  = p.due;
                    p.is_read = cmd_read;
                    p.data    = cmd_read ? $urandom : 32'h0;
                    p.err     = cmd_read && (read_idx == err_beat);
                    pend.push_back(p);
                    if (cmd_read) read_idx++;
                end
                if (acc_take) acc_log.push_back(data_from_acce);
                if (hs) outst_b++;
                if (rsp_valid && outst_b > 0) outst_b--;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    // One complete run checked against the expected command/data sequence for the model bank.
    task automatic run_and_check(input string tag, input logic exp_err);
        bit          done;
        logic [31:0] exp_addr;
        cmd_log.delete(); rd_obs.delete(); rd_exp.delete(); acc_log.delete();
        read_idx = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        done = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
            if (conv_irq === 1'b1) done = 1;
            else step();
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s done: conv_irq never rose", tag);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy: got %b expected 0 after run", tag, busy);
        end
        checks++;
        if (cmd_log.size() != RD_LEN + WR_LEN || acc_log.size() != WR_LEN) begin
            errors++;
            $display("FAIL %s cmd_count: got %0d cmds / %0d accel beats, expected %0d / %0d",
                     tag, cmd_log.size(), acc_log.size(), RD_LEN + WR_LEN, WR_LEN);
        end else begin
            for (int i = 0; i < RD_LEN + WR_LEN; i++) begin
                if (i < RD_LEN)
                    exp_addr = RD_BASE + 32'(bank_m) * BANK_STRIDE + 32'(i) * ADDR_STEP;
                else
                    exp_addr = WR_BASE + 32'(i - RD_LEN) * ADDR_STEP;
                checks++;
                if (cmd_log[i].addr !== exp_addr || cmd_log[i].read !== (i < RD_LEN)) begin
                    errors++;
                    $display("FAIL %s cmd[%0d]: got addr %h read %b, expected addr %h read %b",
                             tag, i, cmd_log[i].addr, cmd_log[i].read, exp_addr, i < RD_LEN);
                end
                if (i >= RD_LEN) begin
                    checks++;
                    if (cmd_log[i].wdata !== acc_log[i - RD_LEN] || cmd_log[i].wmask !== 4'hF) begin
                        errors++;
                        $display("FAIL %s wdata[%0d]: got %h/%h expected %h/f", tag, i - RD_LEN,
                                 cmd_log[i].wdata, cmd_log[i].wmask, acc_log[i - RD_LEN]);
                    end
                end
            end
        end
        checks++;
        if (rd_obs.size() != RD_LEN || rd_exp.size() != RD_LEN) begin
            errors++;
            $display("FAIL %s rd_stream_len: got %0d beats to accel, expected %0d",
                     tag, rd_obs.size(), RD_LEN);
        end else begin
            for (int i = 0; i < RD_LEN; i++) begin
                checks++;
                if (rd_obs[i] !== rd_exp[i]) begin
                    errors++;
                    $display("FAIL %s rd_stream[%0d]: got %h expected %h", tag, i, rd_obs[i], rd_exp[i]);
                end
            end
        end
        bank_m = (bank_m + 1) % NBANK;
        checks++;
        if (bank !== 2'(bank_m)) begin
            errors++;
            $display("FAIL %s bank: got %0d expected %0d", tag, bank, bank_m);
        end
        checks++;
        if (err !== exp_err) begin
            errors++;
            $display("FAIL %s err: got %b expected %b", tag, err, exp_err);
        end
        irq_clr = 1'b1;
        step();
        irq_clr = 1'b0;
        checks++;
        if (conv_irq !== 1'b0) begin
            errors++;
            $display("FAIL %s irq_clr: conv_irq got %b expected 0", tag, conv_irq);
        end
    endtask

    task automatic set_traffic(input int rr, input int ar, input int lmin, input int lmax);
        rdy_rate = rr; acc_rate = ar; lat_min = lmin; lat_max = lmax;
    endtask

    task automatic check_idle_outputs(input string tag);
        checks++;
        if (busy !== 1'b0 || cmd_valid !== 1'b0 || ready_to_acce !== 1'b0 || valid_to_acce !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs: busy %b cmd_valid %b ready_to_acce %b valid_to_acce %b, expected all 0",
                     tag, busy, cmd_valid, ready_to_acce, valid_to_acce);
        end
        checks++;
        if (rsp_ready !== 1'b1 || conv_irq !== 1'b0 || err !== 1'b0 || bank !== 2'd0) begin
            errors++;
            $display("FAIL %s regs: rsp_ready %b conv_irq %b err %b bank %0d, expected 1 0 0 0",
                     tag, rsp_ready, conv_irq, err, bank);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; irq_clr = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        step();
        bank_m = 0;
        check_idle_outputs("reset");
    endtask

    task automatic test_basic();
        set_traffic(100, 100, 1, 1);
        run_and_check("basic", 1'b0);
        checks++;
        if (cmd_log.size() > 0 && cmd_log[0].addr !== 32'h2000_0000) begin
            errors++;
            $display("FAIL basic first_addr: got %h expected 20000000", cmd_log[0].addr);
        end
    endtask

    task automatic test_outstanding_limit();
        set_traffic(100, 100, 10, 10);
        rsp_seen = 0; hs_before = 0;
        run_and_check("outst_limit", 1'b0);
        checks++;
        if (hs_before != MAX_OUTST) begin
            errors++;
            $display("FAIL outst_limit hs_before_rsp: got %0d expected %0d", hs_before, MAX_OUTST);
        end
    endtask

    task automatic test_bank_rotation();
        set_traffic(100, 100, 1, 2);
        run_and_check("bank_wrap", 1'b0);
        checks++;
        if (cmd_log.size() > 0 && cmd_log[0].addr !== 32'h2000_0000) begin
            errors++;
            $display("FAIL bank_wrap first_addr: got %h expected 20000000", cmd_log[0].addr);
        end
    endtask

    task automatic test_acce_toggle();
        set_traffic(70, 40, 1, 4);
        run_and_check("acce_toggle_a", 1'b0);
        set_traffic(100, 30, 1, 3);
        run_and_check("acce_toggle_b", 1'b0);
    endtask

    task automatic test_rsp_err();
        set_traffic(100, 100, 1, 1);
        err_beat = 2;
        run_and_check("rsp_err", 1'b1);
        err_beat = -1;
    endtask

    task automatic test_reset_mid();
        set_traffic(100, 100, 10, 10);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 50 && outst_b != 3; i++) step();
        checks++;
        if (outst_b != 3) begin
            errors++;
            $display("FAIL reset_mid setup: outstanding got %0d expected 3", outst_b);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_obs.delete();
        bank_m = 0;
        check_idle_outputs("reset_mid");
        for (int i = 0; i < 50 && pend.size() != 0; i++) step();
        step();
        checks++;
        if (pend.size() != 0 || rd_obs.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid late_rsp: %0d pending, %0d beats forwarded, busy %b; expected 0 0 0",
                     pend.size(), rd_obs.size(), busy);
        end
        set_traffic(100, 100, 1, 2);
        run_and_check("after_reset", 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int r = 0; r < 3; r++) begin
            set_traffic($urandom_range(40, 100), $urandom_range(30, 100), 1, $urandom_range(1, 6));
            run_and_check($sformatf("b2b_%0d", r), 1'b0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; irq_clr = 1'b0;
        test_reset();
        test_basic();
        test_outstanding_limit();
        test_bank_rotation();
        test_acce_toggle();
        test_rsp_err();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
